// File: rtl/micro_sequencer.sv
// Next-state engine for the microprogrammed control unit. It selects and registers the microstore
// state index, with one return level, a MOC wait timeout and an illegal-state trap.
module micro_sequencer #(
  parameter int unsigned STATE_W    = 7,
  parameter int unsigned LAST_STATE = 38,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         n_sel,
  input  logic               inv,
  input  logic [1:0]         cond_sel,
  input  logic [STATE_W-1:0] cr,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               moc,
  input  logic               cond_in,
  input  logic               irq,
  output logic [STATE_W-1:0] current_state,
  output logic               stall,
  output logic               illegal,
  output logic               timeout
);

  typedef enum logic [2:0] {
    SelDecode   = 3'b000,
    SelInc      = 3'b001,
    SelJump     = 3'b010,
    SelBranch   = 3'b011,
    SelWait     = 3'b100,
    SelDispatch = 3'b101,
    SelCall     = 3'b110,
    SelReturn   = 3'b111
  } sel_e;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] ret_q, ret_d;
  logic [7:0]         wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;

  logic               cond_raw;
  logic               cond;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] mux_nxt;
  logic               wait_hit;
  logic               out_of_range;

  always_comb begin
    cond_raw = 1'b0;
    unique case (cond_sel)
      2'b00:   cond_raw = moc;
      2'b01:   cond_raw = cond_in;
      2'b10:   cond_raw = irq;
      default: cond_raw = 1'b0;
    endcase
  end

  assign cond = cond_raw ^ inv;
  assign inc  = state_q + 1'b1;

  always_comb begin
    mux_nxt = inc;
    stall   = 1'b0;
    ret_d   = ret_q;
    unique case (sel_e'(n_sel))
      SelDecode:   mux_nxt = enc_state;
      SelInc:      mux_nxt = inc;
      SelJump:     mux_nxt = cr;
      SelBranch:   mux_nxt = cond ? cr : inc;
      SelWait: begin
        mux_nxt = cond ? inc : state_q;
        stall   = ~cond;
      end
      SelDispatch: mux_nxt = cond ? enc_state : inc;
      SelCall: begin
        mux_nxt = cr;
        ret_d   = inc;
      end
      SelReturn:   mux_nxt = ret_q;
      default:     mux_nxt = inc;
    endcase
  end

  // The hold edge that would make the WAIT_LIMIT-th consecutive hold escapes to state 0 instead.
  assign wait_hit     = stall && (wait_q == 8'(WAIT_LIMIT - 1));
  assign out_of_range = 32'(mux_nxt) > LAST_STATE;

  always_comb begin
    wait_d    = '0;
    state_d   = mux_nxt;
    illegal_d = illegal_q | out_of_range;
    timeout_d = timeout_q | wait_hit;
    if (stall && !wait_hit) begin
      wait_d = wait_q + 8'd1;
    end
    if (wait_hit || out_of_range) begin
      state_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= '0;
      ret_q     <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign current_state = state_q;
  assign illegal       = illegal_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed and randomized bench for micro_sequencer against a behavioural next-state model.
module tb_micro_sequencer;

  localparam int LastState = 38;
  localparam int WaitLimit = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] n_sel = 3'd1;
  logic       inv = 1'b0;
  logic [1:0] cond_sel = 2'd0;
  logic [6:0] cr = '0;
  logic [6:0] enc_state = '0;
  logic       moc = 1'b0;
  logic       cond_in = 1'b0;
  logic       irq = 1'b0;
  logic [6:0] current_state;
  logic       stall;
  logic       illegal;
  logic       timeout;

  micro_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .n_sel        (n_sel),
    .inv          (inv),
    .cond_sel     (cond_sel),
    .cr           (cr),
    .enc_state    (enc_state),
    .moc          (moc),
    .cond_in      (cond_in),
    .irq          (irq),
    .current_state(current_state),
    .stall        (stall),
    .illegal      (illegal),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int m_state = 0;
  int m_ret   = 0;
  int m_wcnt  = 0;
  int m_ill   = 0;
  int m_to    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_cond();
    int c;
    case (cond_sel)
      2'd0:    c = int'(moc);
      2'd1:    c = int'(cond_in);
      2'd2:    c = int'(irq);
      default: c = 0;
    endcase
    return c ^ int'(inv);
  endfunction

  function automatic int m_stall();
    return (n_sel == 3'd4 && m_cond() == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ret   = 0;
    m_wcnt  = 0;
    m_ill   = 0;
    m_to    = 0;
  endtask

  task automatic model_edge();
    int inc, c, nxt, hold, new_ret;
    inc     = (m_state + 1) % 128;
    c       = m_cond();
    hold    = 0;
    new_ret = m_ret;
    case (n_sel)
      3'd0: nxt = int'(enc_state);
      3'd1: nxt = inc;
      3'd2: nxt = int'(cr);
      3'd3: nxt = c ? int'(cr) : inc;
      3'd4: begin
        nxt  = c ? inc : m_state;
        hold = c ? 0 : 1;
      end
      3'd5: nxt = c ? int'(enc_state) : inc;
      3'd6: begin
        nxt     = int'(cr);
        new_ret = inc;
      end
      default: nxt = m_ret;
    endcase
    if (nxt > LastState) begin
      m_ill = 1;
      nxt   = 0;
    end
    if (hold == 1 && m_wcnt == WaitLimit - 1) begin
      m_to   = 1;
      nxt    = 0;
      m_wcnt = 0;
    end else begin
      m_wcnt = hold ? m_wcnt + 1 : 0;
    end
    m_ret   = new_ret;
    m_state = nxt;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_state"}, 32'(current_state), 32'(m_state));
    check({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
    check({tag, "_timeout"}, 32'(timeout), 32'(m_to));
  endtask

  // Inputs are already applied; check comb stall, clock once, check registered outputs.
  task automatic step(input string tag);
    #1;
    check({tag, "_stall"}, 32'(stall), 32'(m_stall()));
    @(posedge clk);
    model_edge();
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_regs(tag);
    reset = 1'b1;
  endtask

  task automatic set_op(input logic [2:0] sel, input logic [6:0] c_r, input logic [6:0] enc);
    n_sel     = sel;
    cr        = c_r;
    enc_state = enc;
  endtask

  initial begin
    // 1: reset held while clocking INC, then three INC edges
    #1;
    model_reset();
    check_regs("rst0");
    repeat (2) @(posedge clk);
    #1;
    check_regs("rst_clk");
    reset = 1'b1;
    set_op(3'd1, 7'd0, 7'd0);
    step("inc1");
    check("inc1_const", 32'(current_state), 32'd1);
    step("inc2");
    step("inc3");
    check("inc3_const", 32'(current_state), 32'd3);

    // 2: decode legal then illegal target
    do_reset("rst2");
    step("to1");
    set_op(3'd0, 7'd0, 7'd6);
    step("dec6");
    check("dec6_const", 32'(current_state), 32'd6);
    enc_state = 7'd45;
    step("dec45");
    check("dec45_ill", 32'(illegal), 32'd1);
    set_op(3'd1, 7'd0, 7'd0);
    step("ill_sticky1");
    step("ill_sticky2");

    // 3: branch on inverted cond_in
    do_reset("rst3");
    set_op(3'd2, 7'd5, 7'd0);
    step("jmp5a");
    set_op(3'd3, 7'd20, 7'd0);
    cond_sel = 2'd1;
    cond_in  = 1'b1;
    inv      = 1'b1;
    step("br_inv");
    check("br_inv_const", 32'(current_state), 32'd6);
    set_op(3'd2, 7'd5, 7'd0);
    step("jmp5b");
    set_op(3'd3, 7'd20, 7'd0);
    inv = 1'b0;
    step("br_taken");
    check("br_taken_const", 32'(current_state), 32'd20);

    // 4: wait on moc for three edges
    set_op(3'd2, 7'd3, 7'd0);
    step("jmp3");
    set_op(3'd4, 7'd0, 7'd0);
    cond_sel = 2'd0;
    moc      = 1'b0;
    for (int i = 0; i < 3; i++) step("wait_hold");
    check("wait_hold_const", 32'(current_state), 32'd3);
    moc = 1'b1;
    step("wait_done");
    check("wait_done_const", 32'(current_state), 32'd4);

    // 5: moc stuck low until the timeout fires
    moc = 1'b0;
    for (int i = 0; i < WaitLimit; i++) step("wait_to");
    check("to_state_const", 32'(current_state), 32'd0);
    check("to_flag_const", 32'(timeout), 32'd1);
    moc = 1'b1;
    set_op(3'd1, 7'd0, 7'd0);
    step("to_sticky");

    // 6: call/return and reset mid-subroutine
    do_reset("rst6");
    set_op(3'd2, 7'd10, 7'd0);
    step("jmp10");
    set_op(3'd6, 7'd30, 7'd0);
    step("call30");
    set_op(3'd1, 7'd0, 7'd0);
    step("sub_inc");
    set_op(3'd7, 7'd0, 7'd0);
    step("ret");
    check("ret_const", 32'(current_state), 32'd11);
    set_op(3'd6, 7'd30, 7'd0);
    step("call_again");
    set_op(3'd1, 7'd0, 7'd0);
    step("sub_inc2");
    do_reset("rst_mid");
    set_op(3'd7, 7'd0, 7'd0);
    step("ret_after_rst");

    // Return address past the last state traps as illegal
    set_op(3'd2, 7'd38, 7'd0);
    step("jmp38");
    set_op(3'd6, 7'd1, 7'd0);
    step("call_from38");
    set_op(3'd7, 7'd0, 7'd0);
    step("ret39");

    // Randomized traffic, occasional resets
    do_reset("rst_rand");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset("rand_rst");
      end
      n_sel     = 3'($urandom_range(0, 7));
      inv       = 1'($urandom_range(0, 1));
      cond_sel  = 2'($urandom_range(0, 3));
      cr        = 7'($urandom_range(0, 45));
      enc_state = 7'($urandom_range(0, 45));
      moc       = ($urandom_range(0, 3) == 0);
      cond_in   = 1'($urandom_range(0, 1));
      irq       = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
